// File: rtl/multicycle_alu_exec.sv
// rtl/multicycle_alu_exec.sv - registered ALU with start/done handshake, serial shifter; MULT_EN adds iterative multiply
`timescale 1ns/1ps

module multicycle_alu_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   Invalid
);

    localparam int HALF = DATA_WIDTH / 2;
    // One counter serves both the shift amount and the multiply iteration count.
    localparam int MCW  = $clog2(DATA_WIDTH) + 1;
    localparam int CW   = (SHAMT_WIDTH > MCW) ? SHAMT_WIDTH : MCW;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_LUI = 4'b0111;
`ifdef MULT_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef MULT_EN
        ,
        MUL   = 2'd2
`endif
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  shift_left;
    logic [DATA_WIDTH-1:0] sreg_next;
    logic [DATA_WIDTH-1:0] quick_res;
    logic                  quick_valid;
    logic                  is_shift;
    logic                  last_iter;
`ifdef MULT_EN
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
`endif

    assign busy      = (state != IDLE);
    assign is_shift  = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign last_iter = (cnt == CW'(1));
    assign sreg_next = shift_left ? (sreg << 1) : (sreg >> 1);
`ifdef MULT_EN
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
`endif

    // Single-cycle results; SLL/SRL entries cover the shamt==0 case (result = B).
    always_comb begin
        quick_res   = '0;
        quick_valid = 1'b1;
        case (ALUOperation)
            OP_AND: quick_res = A & B;
            OP_OR:  quick_res = A | B;
            OP_NOR: quick_res = ~(A | B);
            OP_ADD: quick_res = A + B;
            OP_SUB: quick_res = A - B;
            OP_SLL: quick_res = B;
            OP_SRL: quick_res = B;
            OP_LUI: quick_res = {B[HALF-1:0], {HALF{1'b0}}};
            default: begin
                quick_res   = '0;
                quick_valid = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: multi-cycle ops leave IDLE, the last iteration returns.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        state_next = SHIFT;
                    end
`ifdef MULT_EN
                    else if (ALUOperation == OP_MUL) begin
                        state_next = MUL;
                    end
`endif
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
`ifdef MULT_EN
            MUL: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands at accept, iterate, and register results with a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            sreg       <= '0;
            shift_left <= 1'b0;
            done       <= 1'b0;
            ALUResult  <= '0;
            Zero       <= 1'b1;
            Invalid    <= 1'b0;
`ifdef MULT_EN
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_shift && (shamt != '0)) begin
                            sreg       <= B;
                            cnt        <= CW'(shamt);
                            shift_left <= (ALUOperation == OP_SLL);
                        end
`ifdef MULT_EN
                        else if (ALUOperation == OP_MUL) begin
                            mcand  <= A;
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= CW'(DATA_WIDTH);
                        end
`endif
                        else begin
                            ALUResult <= quick_res;
                            Zero      <= (quick_res == '0);
                            Invalid   <= ~quick_valid;
                            done      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= sreg_next;
                    cnt  <= cnt - CW'(1);
                    if (last_iter) begin
                        ALUResult <= sreg_next;
                        Zero      <= (sreg_next == '0);
                        Invalid   <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`ifdef MULT_EN
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (last_iter) begin
                        ALUResult <= acc_next;
                        Zero      <= (acc_next == '0);
                        Invalid   <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu_exec.sv
// tb/tb_multicycle_alu_exec.sv - randomized self-checking bench for multicycle_alu_exec
`timescale 1ns/1ps

module tb_multicycle_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Invalid;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_alu_exec #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .Invalid      (Invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: result, invalid flag and number of busy cycles for one op.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic inv,
                         output int lat);
        r   = 32'd0;
        inv = 1'b0;
        lat = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = ~(a | b);
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: begin r = b << sh; lat = int'(sh); end
            4'd6: begin r = b >> sh; lat = int'(sh); end
            4'd7: r = {b[15:0], 16'h0000};
`ifdef MULT_EN
            4'd8: begin r = a * b; lat = 32; end
`endif
            default: inv = 1'b1;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    // Issue one op from a non-busy cycle; operands are scrambled after accept and
    // random ignored starts are driven while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        logic [31:0] er;
        logic        ei;
        int          lat;
        model(op, a, b, sh, er, ei, lat);
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        ALUOperation = 4'($urandom);
        A            = $urandom;
        B            = $urandom;
        shamt        = 5'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= lat) begin
                check("busy_high", busy, 1);
                check("done_early", done, 0);
                start        = 1'($urandom_range(0, 1));
                ALUOperation = 4'($urandom_range(0, 8));
                A            = $urandom;
                B            = $urandom;
                shamt        = 5'($urandom);
            end else begin
                start = 1'b0;
                check("done", done, 1);
                check("busy_done", busy, 0);
                check("result", ALUResult, er);
                check("zero", Zero, (er == 32'd0));
                check("invalid", Invalid, ei);
            end
        end
    endtask

    initial begin
        logic [3:0] op;
        logic [4:0] sh;
        reset        = 1'b0;
        start        = 1'b0;
        ALUOperation = 4'd0;
        A            = 32'd0;
        B            = 32'd0;
        shamt        = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", ALUResult, 0);
        check("rst_zero", Zero, 1);
        check("rst_invalid", Invalid, 0);
        reset = 1'b1;
        idle(2);

        run_op(4'd3, 32'd5, 32'd7, 5'd0);
        idle(1);
        run_op(4'd4, 32'd9, 32'd9, 5'd0);
        run_op(4'd4, 32'd0, 32'd1, 5'd0);
        run_op(4'd5, 32'd1, 32'd1, 5'd4);
        run_op(4'd3, 32'd100, 32'd23, 5'd0);
        run_op(4'd6, 32'd0, 32'h8000_0000, 5'd31);
        run_op(4'd5, 32'd0, 32'hdead_beef, 5'd0);
        run_op(4'd7, 32'd0, 32'h1234_abcd, 5'd0);
        run_op(4'd9, 32'd1, 32'd2, 5'd0);
        run_op(4'd0, 32'hf0f0_f0f0, 32'hff00_ff00, 5'd0);
        run_op(4'd8, 32'd6, 32'd7, 5'd0);
        run_op(4'd2, 32'h0000_ffff, 32'hffff_0000, 5'd0);

        // Reset during SHIFT cycle t+2 aborts the op with no late done.
        ALUOperation = 4'd5;
        B            = 32'd1;
        shamt        = 5'd10;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", ALUResult, 0);
        check("abort_zero", Zero, 1);
        check("abort_invalid", Invalid, 0);
        reset = 1'b1;
        idle(12);

        for (int n = 0; n < 250; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
            case ($urandom_range(0, 3))
                0:       sh = 5'd0;
                1:       sh = 5'd31;
                default: sh = 5'($urandom_range(1, 12));
            endcase
            run_op(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, sh);
            if ($urandom_range(0, 2) == 0) begin
                idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
